// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state and op encodings for the multiply/divide engine
package muldiv_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_RUN_MUL, ST_RUN_DIV, ST_SIGN_FIX, ST_DONE} state_t;
   localparam logic [1:0] OP_MULT = 2'b00;
   localparam logic [1:0] OP_DIV = 2'b01;
   localparam logic [1:0] OP_MULTU = 2'b10;
   localparam logic [1:0] OP_DIVU = 2'b11;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: Booth/restoring iteration registers and Hi/Lo result registers
module muldiv_datapath import muldiv_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             div_in,
   input  logic             sgn_in,
   input  logic             step,
   input  logic             wr,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             mzero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);
   localparam int W = WIDTH;
   logic [W:0] acc, q, acc_n, q_n, r_sh, ext_m, addend, booth;
   logic [W-1:0] m, ua, ub, hi_n, lo_n;
   logic qm1, div, sgn, neg_q, neg_r, ge;
   assign ua = (sgn_in && src_a[W-1]) ? -src_a : src_a;
   assign ub = (sgn_in && src_b[W-1]) ? -src_b : src_b;
   assign mzero = m == '0;
   always_comb begin
      ext_m = {sgn & m[W-1], m};
      addend = (q[0] && !qm1) ? -ext_m : (!q[0] && qm1) ? ext_m : '0;
      booth = acc + addend;
      r_sh = {acc[W-1:0], q[W-1]};
      ge = r_sh >= {1'b0, m};
      acc_n = !step ? acc : div ? (ge ? r_sh - {1'b0, m} : r_sh) : {booth[W], booth[W:1]};
      q_n = !step ? q : div ? {1'b0, q[W-2:0], ge} : {booth[0], q[W:1]};
      // signed mult consumes WIDTH bits so its low half sits one bit higher in q
      lo_n = div ? (neg_q ? -q_n[W-1:0] : q_n[W-1:0]) : sgn ? q_n[W:1] : q_n[W-1:0];
      hi_n = div ? (neg_r ? -acc_n[W-1:0] : acc_n[W-1:0]) : sgn ? acc_n[W-1:0] : {acc_n[W-2:0], q_n[W]};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         q <= '0;
         m <= '0;
         qm1 <= 1'b0;
         div <= 1'b0;
         sgn <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         hi_out <= '0;
         lo_out <= '0;
      end else begin
         if (load) begin
            acc <= '0;
            q <= {div_in ? 1'b0 : sgn_in & src_b[W-1], div_in ? ua : src_b};
            m <= div_in ? ub : src_a;
            qm1 <= 1'b0;
            div <= div_in;
            sgn <= sgn_in;
            neg_q <= div_in & sgn_in & (src_a[W-1] ^ src_b[W-1]);
            neg_r <= div_in & sgn_in & src_a[W-1];
         end else begin
            acc <= acc_n;
            q <= q_n;
            qm1 <= (step && !div) ? q[0] : qm1;
         end
         if (wr) begin
            hi_out <= hi_n;
            lo_out <= lo_n;
         end
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multicycle mult/div FSM and handshake; MULDIV_UNSIGNED_EN enables multu/divu
module muldiv_unit import muldiv_pkg::*; #(
   parameter int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             dzero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, mul_last;
   logic go, div_r, sgn_r, div_in, sgn_in, accept, step, wr, mzero, dz_hit;
   assign div_in = op == OP_DIV || op == OP_DIVU;
`ifdef MULDIV_UNSIGNED_EN
   assign sgn_in = !(op == OP_MULTU || op == OP_DIVU);
`else
   assign sgn_in = 1'b1;
`endif
   // go marks the capture cycle: operands are loaded, the run starts one edge later
   assign accept = state == ST_IDLE && !go && start;
   assign dz_hit = state == ST_IDLE && go && div_r && mzero;
   assign mul_last = sgn_r ? CNT_W'(WIDTH - 1) : CNT_W'(WIDTH);
   assign busy = state == ST_RUN_MUL || state == ST_RUN_DIV || state == ST_SIGN_FIX;
   assign done = state == ST_DONE;
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      step = 1'b0;
      wr = 1'b0;
      case (state)
         ST_IDLE: if (go) begin
            cnt_n = '0;
            state_n = !div_r ? ST_RUN_MUL : mzero ? ST_DONE : ST_RUN_DIV;
         end
         ST_RUN_MUL: begin
            step = 1'b1;
            cnt_n = cnt + 1'b1;
            wr = cnt == mul_last;
            state_n = wr ? ST_DONE : ST_RUN_MUL;
         end
         ST_RUN_DIV: begin
            step = 1'b1;
            cnt_n = cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_n = sgn_r ? ST_SIGN_FIX : ST_DONE;
               wr = !sgn_r;
            end
         end
         ST_SIGN_FIX: begin
            wr = 1'b1;
            state_n = ST_DONE;
         end
         default: state_n = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt <= '0;
         go <= 1'b0;
         div_r <= 1'b0;
         sgn_r <= 1'b0;
         dzero <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         go <= accept;
         if (accept) begin
            div_r <= div_in;
            sgn_r <= sgn_in;
            dzero <= 1'b0;
         end else if (dz_hit) begin
            dzero <= 1'b1;
         end
      end
   end
   muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk(clk),
      .reset(reset),
      .load(accept),
      .div_in(div_in),
      .sgn_in(sgn_in),
      .step(step),
      .wr(wr),
      .src_a(src_a),
      .src_b(src_b),
      .mzero(mzero),
      .hi_out(hi_out),
      .lo_out(lo_out)
   );
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit against an arithmetic reference model
`timescale 1ns/1ps
module tb_muldiv_unit;
   localparam int W = 32;
   logic clk = 1'b0;
   logic reset, start, busy, done, dzero;
   logic [1:0] op;
   logic [W-1:0] src_a, src_b, hi_out, lo_out;
   int checks = 0, errors = 0, edge_cnt = 0, busy_cnt = 0;
   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic dz;
      int k;
      int lat;
      int bsy;
   } exp_t;
   exp_t sb[$];
   exp_t cur;
   logic [W-1:0] last_hi = '0, last_lo = '0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .busy(busy), .done(done), .dzero(dzero), .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output exp_t e);
      logic uns;
      longint sa, sd, p;
      logic [63:0] up, qq, rr;
`ifdef MULDIV_UNSIGNED_EN
      uns = o[1];
`else
      uns = 1'b0;
`endif
      e.dz = 1'b0;
      e.k = 0;
      if (!o[0]) begin
         if (uns) up = {32'b0, a} * {32'b0, b};
         else begin
            p = longint'(signed'(a)) * longint'(signed'(b));
            up = p;
         end
         e.hi = up[63:32];
         e.lo = up[31:0];
         e.lat = uns ? W + 2 : W + 1;
         e.bsy = uns ? W + 1 : W;
      end else if (b == '0) begin
         e.dz = 1'b1;
         e.hi = last_hi;
         e.lo = last_lo;
         e.lat = 1;
         e.bsy = 0;
      end else if (uns) begin
         e.lo = a / b;
         e.hi = a % b;
         e.lat = W + 1;
         e.bsy = W;
      end else begin
         sa = longint'(signed'(a));
         sd = longint'(signed'(b));
         qq = sa / sd;
         rr = sa % sd;
         e.lo = qq[31:0];
         e.hi = rr[31:0];
         e.lat = W + 2;
         e.bsy = W + 1;
      end
      if (!e.dz) begin
         last_hi = e.hi;
         last_lo = e.lo;
      end
   endtask

   always @(negedge clk) begin
      if (reset) busy_cnt = 0;
      else if (done) begin
         if (sb.size() == 0) chk("spurious_done", 1, 0);
         else begin
            cur = sb.pop_front();
            chk("hi", hi_out, cur.hi);
            chk("lo", lo_out, cur.lo);
            chk("dzero", dzero, cur.dz);
            chk("latency", edge_cnt - cur.k, cur.lat);
            chk("busy_cycles", busy_cnt, cur.bsy);
            chk("busy_in_done", busy, 0);
         end
         busy_cnt = 0;
      end else if (busy) busy_cnt++;
   end

   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      model(o, a, b, e);
      e.k = edge_cnt + 1;
      sb.push_back(e);
      start = 1'b1;
      op = o;
      src_a = a;
      src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      chk("dzero_clear", dzero, 0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("timeout", 1, 0);
      @(posedge clk); #1;
   endtask

   task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      issue(o, a, b);
      wait_done();
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'h8000_0000;
         2: return '1;
         3: return 32'd1;
         4: return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op = 2'b00;
      src_a = '0;
      src_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hi", hi_out, 0);
      chk("rst_lo", lo_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dzero", dzero, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      run(2'b00, 32'd7, 32'hFFFF_FFFD);
      run(2'b01, 32'hFFFF_FFF9, 32'd2);
      run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
      run(2'b01, 32'd5, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("dzero_hold", dzero, 1);
      chk("hold_hi", hi_out, 32'h0);
      chk("hold_lo", lo_out, 32'h8000_0000);
      run(2'b00, 32'd6, 32'd9);
      issue(2'b00, 32'h1234_5678, 32'h0000_0F0F);
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1;
      op = 2'b01;
      src_a = 32'd100;
      src_b = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      issue(2'b00, 32'd11, 32'd13);
      while (!done) @(negedge clk);
      start = 1'b1;
      op = 2'b01;
      src_a = 32'd9;
      src_b = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("start_in_done_ignored", busy, 0);
      issue(2'b01, 32'hDEAD_BEEF, 32'd77);
      repeat (14) @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      last_hi = '0;
      last_lo = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_hi", hi_out, 0);
      chk("abort_lo", lo_out, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_dzero", dzero, 0);
      repeat (40) @(posedge clk);
      #1;
      run(2'b00, 32'd3, 32'd4);
      chk("post_reset_lo", lo_out, 12);
      run(2'b10, 32'hFFFF_FFFF, 32'd2);
      run(2'b11, 32'hFFFF_FFF9, 32'd2);
      run(2'b11, 32'd5, 32'd0);
      for (int i = 0; i < 48; i++) run(2'($urandom_range(0, 3)), pick(), pick());
      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
